// File: rtl/drawunit_q_pkg.sv
// drawunit_q shared definitions: opcodes, argument field layout,
// FSM encodings and the queued command / rectangle bundles.
package drawunit_q_pkg;

   localparam logic [7:0] DRAW_CMD_RECT  = 8'h01;
   localparam logic [7:0] DRAW_CMD_CLEAR = 8'h02;

   localparam int X_LSB = 0;
   localparam int Y_LSB = 10;
   localparam int W_LSB = 20;
   localparam int H_LSB = 30;
   localparam int C_LSB = 40;
   localparam int ARG_W = 56;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DRAW,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      E_IDLE,
      E_REQ,
      E_DATA,
      E_FIN
   } eng_t;

   typedef struct packed {
      logic [7:0]       op;
      logic [ARG_W-1:0] args;
   } cmd_t;

   typedef struct packed {
      logic [9:0]  x;
      logic [9:0]  y;
      logic [9:0]  w;
      logic [9:0]  h;
      logic [15:0] color;
   } rect_t;

   function automatic rect_t unpack_rect(input logic [ARG_W-1:0] a);
      rect_t r;
      r.x     = a[X_LSB +: 10];
      r.y     = a[Y_LSB +: 10];
      r.w     = a[W_LSB +: 10];
      r.h     = a[H_LSB +: 10];
      r.color = a[C_LSB +: 16];
      return r;
   endfunction

   // Row-major frame buffer with a fixed 1024-pixel line pitch.
   function automatic logic [21:0] burst_addr(input logic [9:0] x,
                                              input logic [9:0] y,
                                              input logic [9:0] row);
      logic [10:0] line;
      line = 11'(y) + 11'(row);
      return {1'b0, line, x};
   endfunction

endpackage

// File: rtl/drawrect.sv
// Rectangle fill engine: one SDRAM write burst per row while en is high.
// Ports: clk/rst_n, en, rect geometry/color in, burst req/addr/len/rgb out, done.
module drawrect
   import drawunit_q_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic [9:0]  w,
   input  logic [9:0]  h,
   input  logic [15:0] color,
   input  logic        write_burst_data_req,
   input  logic        write_burst_data_finish,
   output logic        write_burst_req,
   output logic [15:0] rgb,
   output logic [21:0] addr,
   output logic [9:0]  write_burst_len,
   output logic        done
);

   eng_t       st;
   logic [9:0] row;

   // Dropping en abandons any work and rearms the engine.
   always_ff @(posedge clk) begin
      if (!rst_n || !en) begin
         st              <= E_IDLE;
         row             <= '0;
         write_burst_req <= 1'b0;
         rgb             <= '0;
         addr            <= '0;
         write_burst_len <= '0;
         done            <= 1'b0;
      end else begin
         unique case (st)
            E_IDLE: begin
               st              <= E_REQ;
               row             <= '0;
               write_burst_req <= 1'b1;
               addr            <= burst_addr(x, y, 10'd0);
               write_burst_len <= w;
               rgb             <= color;
            end
            // Request is held until the controller starts the data phase.
            E_REQ: begin
               if (write_burst_data_req) begin
                  write_burst_req <= 1'b0;
                  st              <= E_DATA;
               end
            end
            E_DATA: begin
               if (write_burst_data_finish) begin
                  if (row == h - 10'd1) begin
                     done <= 1'b1;
                     st   <= E_FIN;
                  end else begin
                     row             <= row + 10'd1;
                     write_burst_req <= 1'b1;
                     addr            <= burst_addr(x, y, row + 10'd1);
                     st              <= E_REQ;
                  end
               end
            end
            E_FIN: st <= E_FIN;
            default: st <= E_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/drawunit_fifo.sv
// Generic synchronous FIFO with flush and occupancy level.
// Ports: clk/rst_n, flush, push/din, pop/dout (head, fall-through), full, empty, level.
module drawunit_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   typedef logic [AW:0] ptr_t;

   logic [WIDTH-1:0] mem [DEPTH];
   ptr_t             wptr;
   ptr_t             rptr;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push & ~full & ~flush;
   assign pop_ok  = pop & ~empty & ~flush;

   // Extra pointer bit separates full from empty.
   assign level = wptr - rptr;
   assign empty = (wptr == rptr);
   assign full  = (level == ptr_t'(DEPTH));
   assign dout  = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else if (flush) begin
         rptr <= wptr;
      end else begin
         if (push_ok) wptr <= wptr + ptr_t'(1);
         if (pop_ok)  rptr <= rptr + ptr_t'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/drawunit_q.sv
// Queued draw-command unit: FIFO of {opcode, args}, decode FSM, drawrect engine.
// Ports: cmd valid/ready/command/data, flush, SDRAM burst port, cmd_done, busy, queue_level, err_count.
module drawunit_q #(
   parameter int CMD_DEPTH = 4,
   parameter int SCREEN_W  = 640,
   parameter int SCREEN_H  = 480,
   parameter int ERR_W     = 8,
   localparam int LW       = $clog2(CMD_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [7:0]       command,
   input  logic [255:0]     data,
   input  logic             flush,
   output logic             write_burst_req,
   input  logic             write_burst_data_req,
   input  logic             write_burst_data_finish,
   output logic [15:0]      rgb,
   output logic [21:0]      addr,
   output logic [9:0]       write_burst_len,
   output logic             cmd_done,
   output logic             busy,
   output logic [LW-1:0]    queue_level,
   output logic [ERR_W-1:0] err_count
);

   import drawunit_q_pkg::*;

   state_t            state_q;
   state_t            state_d;
   cmd_t              fifo_dout;
   cmd_t              head_q;
   rect_t             rect_q;
   rect_t             ld_rect;
   logic [ERR_W-1:0]  err_q;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic              known;
   logic              zero_sz;
   logic              in_draw;
   logic              eng_req;
   logic              eng_done;
   logic [15:0]       eng_rgb;
   logic [21:0]       eng_addr;
   logic [9:0]        eng_len;
   logic              unused_args;

   assign unused_args = ^data[255:ARG_W];

   assign cmd_ready = rst_n & ~full & ~flush;
   assign push      = cmd_valid & cmd_ready;
   assign pop       = (state_q == ST_IDLE) & ~empty & ~flush;
   assign err_count = err_q;

   drawunit_fifo #(
      .WIDTH ($bits(cmd_t)),
      .DEPTH (CMD_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (push),
      .din   ({command, data[ARG_W-1:0]}),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty),
      .level (queue_level)
   );

   // CLEAR reuses the rectangle path with full-screen geometry.
   always_comb begin
      ld_rect = unpack_rect(head_q.args);
      known   = 1'b1;
      unique case (1'b1)
         head_q.op == DRAW_CMD_RECT: known = 1'b1;
         head_q.op == DRAW_CMD_CLEAR: begin
            ld_rect.x = '0;
            ld_rect.y = '0;
            ld_rect.w = 10'(SCREEN_W);
            ld_rect.h = 10'(SCREEN_H);
         end
         default: known = 1'b0;
      endcase
      zero_sz = (ld_rect.w == '0) | (ld_rect.h == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (pop) state_d = ST_LOAD;
         ST_LOAD: begin
            if (!known)       state_d = ST_IDLE;
            else if (zero_sz) state_d = ST_DONE;
            else              state_d = ST_DRAW;
         end
         ST_DRAW: if (eng_done) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q <= '0;
         rect_q <= '0;
         err_q  <= '0;
      end else begin
         if (pop) head_q <= fifo_dout;
         if (state_q == ST_LOAD) begin
            rect_q <= ld_rect;
            if (!known && err_q != '1) err_q <= err_q + ERR_W'(1);
         end
      end
   end

   always_comb begin
      in_draw         = (state_q == ST_DRAW);
      write_burst_req = in_draw & eng_req;
      rgb             = in_draw ? eng_rgb  : '0;
      addr            = in_draw ? eng_addr : '0;
      write_burst_len = in_draw ? eng_len  : '0;
      cmd_done        = (state_q == ST_DONE);
      busy            = (state_q != ST_IDLE) | ~empty;
   end

   drawrect u_rect (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .en                      (in_draw),
      .x                       (rect_q.x),
      .y                       (rect_q.y),
      .w                       (rect_q.w),
      .h                       (rect_q.h),
      .color                   (rect_q.color),
      .write_burst_data_req    (write_burst_data_req),
      .write_burst_data_finish (write_burst_data_finish),
      .write_burst_req         (eng_req),
      .rgb                     (eng_rgb),
      .addr                    (eng_addr),
      .write_burst_len         (eng_len),
      .done                    (eng_done)
   );

endmodule

// File: tb/tb_drawunit_q.sv
// Bench for drawunit_q: random command streams against a row-list model
// of the frame-buffer writes, plus a simple SDRAM burst responder.
module tb_drawunit_q;

   localparam int SW = 640;
   localparam int SH = 480;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [7:0]   command = '0;
   logic [255:0] data = '0;
   logic         flush = 1'b0;
   logic         write_burst_req;
   logic         data_req = 1'b0;
   logic         data_fin = 1'b0;
   logic [15:0]  rgb;
   logic [21:0]  addr;
   logic [9:0]   write_burst_len;
   logic         cmd_done;
   logic         busy;
   logic [2:0]   queue_level;
   logic [7:0]   err_count;

   int checks = 0;
   int passed = 0;
   int stall = 0;
   int exp_err = 0;
   logic [47:0] obs_b[$];
   logic [47:0] exp_b[$];
   int obs_m[$];
   int exp_m[$];

   always #5 clk = ~clk;

   drawunit_q #(
      .CMD_DEPTH (4),
      .SCREEN_W  (SW),
      .SCREEN_H  (SH),
      .ERR_W     (8)
   ) dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .cmd_valid               (cmd_valid),
      .cmd_ready               (cmd_ready),
      .command                 (command),
      .data                    (data),
      .flush                   (flush),
      .write_burst_req         (write_burst_req),
      .write_burst_data_req    (data_req),
      .write_burst_data_finish (data_fin),
      .rgb                     (rgb),
      .addr                    (addr),
      .write_burst_len         (write_burst_len),
      .cmd_done                (cmd_done),
      .busy                    (busy),
      .queue_level             (queue_level),
      .err_count               (err_count)
   );

   // SDRAM responder: log each burst, stall, strobe data, then finish.
   initial begin
      forever begin
         @(negedge clk);
         if (write_burst_req === 1'b1) begin
            obs_b.push_back({addr, write_burst_len, rgb});
            repeat (stall) @(negedge clk);
            data_req = 1'b1;
            repeat (2) @(negedge clk);
            data_req = 1'b0;
            data_fin = 1'b1;
            @(negedge clk);
            data_fin = 1'b0;
         end
      end
   end

   always @(negedge clk)
      if (rst_n && cmd_done === 1'b1) obs_m.push_back(obs_b.size());

   function automatic logic [55:0] mk(input int x, input int y, input int w,
                                      input int h, input logic [15:0] c);
      return {c, 10'(h), 10'(w), 10'(y), 10'(x)};
   endfunction

   // Expected frame-buffer writes: one burst per row of the rectangle.
   task automatic model_cmd(input logic [7:0] op, input logic [55:0] a);
      int x, y, w, h;
      if (op == 8'h01) begin
         x = int'(a[9:0]); y = int'(a[19:10]);
         w = int'(a[29:20]); h = int'(a[39:30]);
      end else if (op == 8'h02) begin
         x = 0; y = 0; w = SW; h = SH;
      end else begin
         if (exp_err < 255) exp_err++;
         return;
      end
      if (w > 0 && h > 0)
         for (int r = 0; r < h; r++)
            exp_b.push_back({22'((y + r) * 1024 + x), 10'(w), a[55:40]});
      exp_m.push_back(exp_b.size());
   endtask

   task automatic push(input logic [7:0] op, input logic [55:0] a,
                       output int held);
      @(negedge clk);
      cmd_valid = 1'b1;
      command = op;
      data = '0;
      data[255:224] = $urandom;
      data[55:0] = a;
      held = 0;
      while (!cmd_ready && held < 3000) begin
         @(negedge clk);
         held++;
      end
      if (!cmd_ready) begin
         checks++;
         $display("FAIL push_timeout: cmd_ready=%b after %0d cycles, required 1",
                  cmd_ready, held);
      end
      @(posedge clk);
      model_cmd(op, a);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 20000);
      if (busy) begin
         checks++;
         $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic clear_q();
      obs_b.delete(); exp_b.delete(); obs_m.delete(); exp_m.delete();
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b0)
         $display("FAIL reset_ready: got %b, required 0", cmd_ready);
      else passed++;
      checks++;
      if ({write_burst_req, rgb, addr, write_burst_len, cmd_done, busy,
           queue_level, err_count} !== '0)
         $display("FAIL reset_outputs: req=%b rgb=%h addr=%h len=%0d done=%b busy=%b lvl=%0d err=%0d, required all 0",
                  write_burst_req, rgb, addr, write_burst_len, cmd_done, busy,
                  queue_level, err_count);
      else passed++;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1)
         $display("FAIL ready_after_reset: got %b, required 1", cmd_ready);
      else passed++;
   endtask

   task automatic test_rect();
      int h, n, bad;
      clear_q();
      stall = 0;
      push(8'h01, mk(10, 20, 4, 2, 16'hF800), h);
      n = 0;
      while (cmd_done !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (cmd_done !== 1'b1 || busy !== 1'b1)
         $display("FAIL rect_done_busy: done=%b busy=%b, required 1 1", cmd_done, busy);
      else passed++;
      @(negedge clk);
      checks++;
      if (cmd_done !== 1'b0 || busy !== 1'b0)
         $display("FAIL rect_after_pulse: done=%b busy=%b, required 0 0", cmd_done, busy);
      else passed++;
      wait_idle();
      bad = 0;
      foreach (exp_b[i]) if (i >= obs_b.size() || obs_b[i] !== exp_b[i]) bad++;
      checks++;
      if (bad != 0 || obs_b.size() != 2 || obs_b.size() != exp_b.size())
         $display("FAIL rect_bursts: got %0d bursts (%0d wrong), required %0d",
                  obs_b.size(), bad, exp_b.size());
      else passed++;
      checks++;
      if (obs_m.size() != 1)
         $display("FAIL rect_done_count: got %0d, required 1", obs_m.size());
      else passed++;
   endtask

   task automatic test_back_to_back();
      int h, bad;
      clear_q();
      stall = 30;
      for (int i = 0; i < 5; i++)
         push(8'h01, mk($urandom_range(0, 1000), $urandom_range(0, 1000),
                        $urandom_range(1, 8), $urandom_range(1, 3),
                        16'($urandom)), h);
      @(negedge clk);
      checks++;
      if (queue_level !== 3'd4 || cmd_ready !== 1'b0)
         $display("FAIL b2b_full: level=%0d ready=%b, required 4 0",
                  queue_level, cmd_ready);
      else passed++;
      push(8'h01, mk($urandom_range(0, 1000), $urandom_range(0, 1000),
                     $urandom_range(1, 8), $urandom_range(1, 3),
                     16'($urandom)), h);
      checks++;
      if (h < 1)
         $display("FAIL b2b_held: sixth push waited %0d cycles, required >=1", h);
      else passed++;
      wait_idle();
      bad = 0;
      foreach (exp_b[i]) if (i >= obs_b.size() || obs_b[i] !== exp_b[i]) bad++;
      checks++;
      if (bad != 0 || obs_b.size() != exp_b.size())
         $display("FAIL b2b_bursts: got %0d bursts (%0d wrong), required %0d",
                  obs_b.size(), bad, exp_b.size());
      else passed++;
      bad = 0;
      foreach (exp_m[i]) if (i >= obs_m.size() || obs_m[i] != exp_m[i]) bad++;
      checks++;
      if (bad != 0 || obs_m.size() != exp_m.size())
         $display("FAIL b2b_done_order: got %0d pulses (%0d misplaced), required %0d",
                  obs_m.size(), bad, exp_m.size());
      else passed++;
   endtask

   task automatic test_clear();
      int h, bad;
      clear_q();
      stall = 0;
      push(8'h02, mk($urandom_range(0, 1000), $urandom_range(0, 1000),
                     $urandom_range(0, 1000), $urandom_range(0, 1000),
                     16'h001F), h);
      wait_idle();
      bad = 0;
      foreach (exp_b[i]) if (i >= obs_b.size() || obs_b[i] !== exp_b[i]) bad++;
      checks++;
      if (bad != 0 || obs_b.size() != SH || obs_b.size() != exp_b.size())
         $display("FAIL clear_bursts: got %0d bursts (%0d wrong), required %0d",
                  obs_b.size(), bad, SH);
      else passed++;
      checks++;
      if (obs_m.size() != 1)
         $display("FAIL clear_done_count: got %0d, required 1", obs_m.size());
      else passed++;
   endtask

   task automatic test_unknown_zero();
      int h;
      clear_q();
      push(8'h7E, mk(5, 5, 5, 5, 16'h1234), h);
      push(8'h01, mk($urandom_range(0, 1000), $urandom_range(0, 1000), 0,
                     $urandom_range(1, 5), 16'($urandom)), h);
      wait_idle();
      checks++;
      if (err_count !== 8'(exp_err) || exp_err != 1)
         $display("FAIL unknown_err: got %0d, required %0d", err_count, exp_err);
      else passed++;
      checks++;
      if (obs_b.size() != 0 || obs_m.size() != 1 || obs_m.size() != exp_m.size())
         $display("FAIL zero_rect: bursts=%0d pulses=%0d, required 0 1",
                  obs_b.size(), obs_m.size());
      else passed++;
   endtask

   task automatic test_flush();
      int h, n, bad;
      logic [55:0] a0;
      clear_q();
      stall = 10;
      a0 = mk($urandom_range(0, 1000), $urandom_range(0, 1000),
              $urandom_range(1, 8), 2, 16'($urandom));
      push(8'h01, a0, h);
      push(8'h01, mk(1, 2, 3, 2, 16'hAAAA), h);
      push(8'h01, mk(4, 5, 6, 2, 16'h5555), h);
      n = 0;
      while (write_burst_req !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (write_burst_req !== 1'b1 || queue_level !== 3'd2)
         $display("FAIL flush_setup: req=%b level=%0d, required 1 2",
                  write_burst_req, queue_level);
      else passed++;
      flush = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b0)
         $display("FAIL flush_ready: got %b, required 0", cmd_ready);
      else passed++;
      @(negedge clk);
      flush = 1'b0;
      checks++;
      if (queue_level !== 3'd0)
         $display("FAIL flush_level: got %0d, required 0", queue_level);
      else passed++;
      wait_idle();
      exp_b.delete(); exp_m.delete();
      model_cmd(8'h01, a0);
      bad = 0;
      foreach (exp_b[i]) if (i >= obs_b.size() || obs_b[i] !== exp_b[i]) bad++;
      checks++;
      if (bad != 0 || obs_b.size() != exp_b.size() || obs_m.size() != 1)
         $display("FAIL flush_result: bursts=%0d (%0d wrong) pulses=%0d, required %0d 1",
                  obs_b.size(), bad, obs_m.size(), exp_b.size());
      else passed++;
   endtask

   task automatic test_random();
      int h, bad, k;
      logic [7:0] op;
      clear_q();
      stall = $urandom_range(0, 3);
      for (int i = 0; i < 10; i++) begin
         k = $urandom_range(0, 9);
         op = (k < 7) ? 8'h01 : 8'($urandom_range(3, 255));
         push(op, mk($urandom_range(0, 1000), $urandom_range(0, 1000),
                     (k == 6) ? 0 : $urandom_range(1, 6),
                     $urandom_range(1, 3), 16'($urandom)), h);
         repeat ($urandom_range(0, 4)) @(negedge clk);
      end
      wait_idle();
      bad = 0;
      foreach (exp_b[i]) if (i >= obs_b.size() || obs_b[i] !== exp_b[i]) bad++;
      checks++;
      if (bad != 0 || obs_b.size() != exp_b.size())
         $display("FAIL random_bursts: got %0d (%0d wrong), required %0d",
                  obs_b.size(), bad, exp_b.size());
      else passed++;
      bad = 0;
      foreach (exp_m[i]) if (i >= obs_m.size() || obs_m[i] != exp_m[i]) bad++;
      checks++;
      if (bad != 0 || obs_m.size() != exp_m.size())
         $display("FAIL random_done: got %0d pulses (%0d misplaced), required %0d",
                  obs_m.size(), bad, exp_m.size());
      else passed++;
      checks++;
      if (err_count !== 8'(exp_err))
         $display("FAIL random_err: got %0d, required %0d", err_count, exp_err);
      else passed++;
   endtask

   task automatic test_reset_mid_draw();
      int h, n;
      clear_q();
      stall = 20;
      push(8'h01, mk(7, 8, 5, 3, 16'hBEEF), h);
      push(8'h01, mk(9, 9, 2, 2, 16'h0F0F), h);
      n = 0;
      while (write_burst_req !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (write_burst_req !== 1'b1 || err_count === 8'd0)
         $display("FAIL middraw_setup: req=%b err=%0d, required 1 nonzero",
                  write_burst_req, err_count);
      else passed++;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      exp_err = 0;
      checks++;
      if ({write_burst_req, rgb, addr, write_burst_len, cmd_done, busy,
           queue_level} !== '0 || err_count !== 8'(exp_err))
         $display("FAIL middraw_reset: req=%b lvl=%0d err=%0d busy=%b done=%b, required all 0",
                  write_burst_req, queue_level, err_count, busy, cmd_done);
      else passed++;
      repeat (40) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_rect();
      test_back_to_back();
      test_clear();
      test_unknown_zero();
      test_flush();
      test_random();
      test_reset_mid_draw();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
